// File: rtl/ysyx_22040386_mem_arb.sv
// Two-requester memory arbiter: instruction fetch (IF) and load/store (LS) share one memory port.
// It runs one transaction at a time, and the current owner is encoded in the FSM state.
module ysyx_22040386_mem_arb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LS_PRIO = 0
) (
    input  logic                  i_ARB_clk,
    input  logic                  i_ARB_rst_n,
    input  logic                  i_ARB_if_req,
    input  logic [ADDR_W-1:0]     i_ARB_if_addr,
    output logic                  o_ARB_if_gnt,
    output logic                  o_ARB_if_rvalid,
    output logic [DATA_W-1:0]     o_ARB_if_rdata,
    input  logic                  i_ARB_ls_req,
    input  logic                  i_ARB_ls_wen,
    input  logic [ADDR_W-1:0]     i_ARB_ls_addr,
    input  logic [DATA_W-1:0]     i_ARB_ls_wdata,
    input  logic [DATA_W/8-1:0]   i_ARB_ls_wmask,
    output logic                  o_ARB_ls_gnt,
    output logic                  o_ARB_ls_rvalid,
    output logic [DATA_W-1:0]     o_ARB_ls_rdata,
    output logic                  o_ARB_mem_req,
    output logic                  o_ARB_mem_wen,
    output logic [ADDR_W-1:0]     o_ARB_mem_addr,
    output logic [DATA_W-1:0]     o_ARB_mem_wdata,
    output logic [DATA_W/8-1:0]   o_ARB_mem_wmask,
    input  logic                  i_ARB_mem_ready,
    input  logic                  i_ARB_mem_rvalid,
    input  logic [DATA_W-1:0]     i_ARB_mem_rdata
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IF  = 3'd1,
        REQ_LS  = 3'd2,
        WAIT_IF = 3'd3,
        WAIT_LS = 3'd4
    } state_e;

    state_e              state_q;
    logic                last_ls_q;
    logic                mem_req_q;
    logic                mem_wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_wmask_q;
    logic                pick_if;
    logic                pick_ls;

    // On a tie, LS wins when prioritised; otherwise the requester that did not own the last transaction wins.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (i_ARB_rst_n && state_q == IDLE) begin
            if (i_ARB_if_req && i_ARB_ls_req) begin
                pick_ls = (LS_PRIO != 0) || !last_ls_q;
                pick_if = !pick_ls;
            end else begin
                pick_if = i_ARB_if_req;
                pick_ls = i_ARB_ls_req;
            end
        end
    end

    always_ff @(posedge i_ARB_clk) begin
        if (!i_ARB_rst_n) begin
            state_q     <= IDLE;
            last_ls_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_if) begin
                        state_q     <= REQ_IF;
                        last_ls_q   <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= i_ARB_if_addr;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                    end else if (pick_ls) begin
                        state_q     <= REQ_LS;
                        last_ls_q   <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= i_ARB_ls_wen;
                        mem_addr_q  <= i_ARB_ls_addr;
                        mem_wdata_q <= i_ARB_ls_wdata;
                        mem_wmask_q <= i_ARB_ls_wmask;
                    end
                end
                REQ_IF: begin
                    if (i_ARB_mem_ready) begin
                        state_q   <= WAIT_IF;
                        mem_req_q <= 1'b0;
                    end
                end
                REQ_LS: begin
                    if (i_ARB_mem_ready) begin
                        state_q   <= WAIT_LS;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT_IF: begin
                    if (i_ARB_mem_rvalid) state_q <= IDLE;
                end
                WAIT_LS: begin
                    if (i_ARB_mem_rvalid) state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ARB_if_gnt    = pick_if;
    assign o_ARB_ls_gnt    = pick_ls;
    assign o_ARB_if_rvalid = i_ARB_rst_n && (state_q == WAIT_IF) && i_ARB_mem_rvalid;
    assign o_ARB_ls_rvalid = i_ARB_rst_n && (state_q == WAIT_LS) && i_ARB_mem_rvalid;
    assign o_ARB_if_rdata  = i_ARB_mem_rdata;
    assign o_ARB_ls_rdata  = i_ARB_mem_rdata;
    assign o_ARB_mem_req   = mem_req_q;
    assign o_ARB_mem_wen   = mem_wen_q;
    assign o_ARB_mem_addr  = mem_addr_q;
    assign o_ARB_mem_wdata = mem_wdata_q;
    assign o_ARB_mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_22040386_mem_arb.sv
// Directed bench for ysyx_22040386_mem_arb: dut0 is round-robin and driven by hand,
// dut1 is LS-priority and is served by a small always-ready memory.
module tb_ysyx_22040386_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_wen;
    logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_ready0, mem_rvalid0;
    logic        mem_rvalid1;

    logic        if_gnt0, if_rvalid0, ls_gnt0, ls_rvalid0, mem_req0, mem_wen0;
    logic [63:0] if_rdata0, ls_rdata0, mem_addr0, mem_wdata0;
    logic [7:0]  mem_wmask0;
    logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_req1, mem_wen1;
    logic [63:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
    logic [7:0]  mem_wmask1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040386_mem_arb #(.ADDR_W(64), .DATA_W(64), .LS_PRIO(0)) dut0 (
        .i_ARB_clk(clk), .i_ARB_rst_n(rst_n),
        .i_ARB_if_req(if_req), .i_ARB_if_addr(if_addr),
        .o_ARB_if_gnt(if_gnt0), .o_ARB_if_rvalid(if_rvalid0), .o_ARB_if_rdata(if_rdata0),
        .i_ARB_ls_req(ls_req), .i_ARB_ls_wen(ls_wen), .i_ARB_ls_addr(ls_addr),
        .i_ARB_ls_wdata(ls_wdata), .i_ARB_ls_wmask(ls_wmask),
        .o_ARB_ls_gnt(ls_gnt0), .o_ARB_ls_rvalid(ls_rvalid0), .o_ARB_ls_rdata(ls_rdata0),
        .o_ARB_mem_req(mem_req0), .o_ARB_mem_wen(mem_wen0), .o_ARB_mem_addr(mem_addr0),
        .o_ARB_mem_wdata(mem_wdata0), .o_ARB_mem_wmask(mem_wmask0),
        .i_ARB_mem_ready(mem_ready0), .i_ARB_mem_rvalid(mem_rvalid0), .i_ARB_mem_rdata(mem_rdata)
    );

    ysyx_22040386_mem_arb #(.ADDR_W(64), .DATA_W(64), .LS_PRIO(1)) dut1 (
        .i_ARB_clk(clk), .i_ARB_rst_n(rst_n),
        .i_ARB_if_req(if_req), .i_ARB_if_addr(if_addr),
        .o_ARB_if_gnt(if_gnt1), .o_ARB_if_rvalid(if_rvalid1), .o_ARB_if_rdata(if_rdata1),
        .i_ARB_ls_req(ls_req), .i_ARB_ls_wen(ls_wen), .i_ARB_ls_addr(ls_addr),
        .i_ARB_ls_wdata(ls_wdata), .i_ARB_ls_wmask(ls_wmask),
        .o_ARB_ls_gnt(ls_gnt1), .o_ARB_ls_rvalid(ls_rvalid1), .o_ARB_ls_rdata(ls_rdata1),
        .o_ARB_mem_req(mem_req1), .o_ARB_mem_wen(mem_wen1), .o_ARB_mem_addr(mem_addr1),
        .o_ARB_mem_wdata(mem_wdata1), .o_ARB_mem_wmask(mem_wmask1),
        .i_ARB_mem_ready(1'b1), .i_ARB_mem_rvalid(mem_rvalid1), .i_ARB_mem_rdata(mem_rdata)
    );

    // Memory for dut1 accepts immediately and acks exactly one cycle after the accepted request.
    always @(posedge clk) mem_rvalid1 <= rst_n & mem_req1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        if_req = 0; ls_req = 0; ls_wen = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_ready0 = 0; mem_rvalid0 = 0; mem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if ({if_gnt0, ls_gnt0, if_rvalid0, ls_rvalid0, mem_req0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {if_gnt0, ls_gnt0, if_rvalid0, ls_rvalid0, mem_req0});
        end
        checks++;
        if ({mem_wen0, mem_addr0, mem_wdata0, mem_wmask0} !== 137'b0) begin
            errors++;
            $display("FAIL reset_cmd got wen=%b addr=%h wdata=%h wmask=%h want all 0",
                     mem_wen0, mem_addr0, mem_wdata0, mem_wmask0);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_fetch;
        do_reset();
        if_req = 1; if_addr = 64'h8000_0000;
        #1;
        checks++;
        if ({if_gnt0, ls_gnt0} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt got %b want 10", {if_gnt0, ls_gnt0});
        end
        tick();
        if_req = 0; if_addr = 64'hFFFF_0000; mem_ready0 = 1;
        #1;
        checks++;
        if ({mem_req0, mem_wen0, mem_addr0, mem_wmask0} !== {1'b1, 1'b0, 64'h8000_0000, 8'h00}) begin
            errors++;
            $display("FAIL fetch_cmd got req=%b wen=%b addr=%h wmask=%h want 1 0 80000000 00",
                     mem_req0, mem_wen0, mem_addr0, mem_wmask0);
        end
        tick();
        mem_ready0 = 0; mem_rvalid0 = 1; mem_rdata = 64'h0000_0013_0000_0093;
        #1;
        checks++;
        if ({if_rvalid0, ls_rvalid0, mem_req0} !== 3'b100 || if_rdata0 !== 64'h0000_0013_0000_0093) begin
            errors++;
            $display("FAIL fetch_rvalid got ifv=%b lsv=%b req=%b data=%h want 1 0 0 0000001300000093",
                     if_rvalid0, ls_rvalid0, mem_req0, if_rdata0);
        end
        tick();
        mem_rvalid0 = 0;
        #1;
        checks++;
        if ({if_rvalid0, ls_rvalid0, mem_req0} !== 3'b000) begin
            errors++; $display("FAIL fetch_done got %b want 000", {if_rvalid0, ls_rvalid0, mem_req0});
        end
        $display("test_single_fetch done");
    endtask

    task automatic test_store;
        do_reset();
        ls_req = 1; ls_wen = 1; ls_addr = 64'h8000_1000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        #1;
        checks++;
        if ({if_gnt0, ls_gnt0} !== 2'b01) begin
            errors++; $display("FAIL store_gnt got %b want 01", {if_gnt0, ls_gnt0});
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            ls_req = 0; ls_wen = 0; ls_addr = 64'h1; ls_wdata = 64'h2; ls_wmask = 8'hF0;
            mem_ready0 = (c == 3);
            #1;
            checks++;
            if ({mem_req0, mem_wen0, mem_addr0, mem_wdata0, mem_wmask0} !==
                {1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
                errors++;
                $display("FAIL store_req_c%0d got req=%b wen=%b addr=%h wdata=%h wmask=%h want 1 1 80001000 deadbeef 0f",
                         c, mem_req0, mem_wen0, mem_addr0, mem_wdata0, mem_wmask0);
            end
        end
        tick();
        mem_ready0 = 0; mem_rvalid0 = 1;
        #1;
        checks++;
        if ({mem_req0, ls_rvalid0, if_rvalid0} !== 3'b010) begin
            errors++; $display("FAIL store_ack got req/lsv/ifv=%b want 010", {mem_req0, ls_rvalid0, if_rvalid0});
        end
        tick();
        mem_rvalid0 = 0;
        $display("test_store done");
    endtask

    task automatic test_round_robin;
        do_reset();
        if_req = 1; ls_req = 1; ls_wen = 0; if_addr = 64'h100; ls_addr = 64'h200;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++;
            if ({if_gnt0, ls_gnt0} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_gnt_t%0d got %b want %b", t, {if_gnt0, ls_gnt0}, (t % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
            mem_ready0 = 1;
            tick();
            mem_ready0 = 0; mem_rvalid0 = 1; mem_rdata = 64'(t);
            #1;
            checks++;
            if ({if_rvalid0, ls_rvalid0} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_rvalid_t%0d got %b want %b", t, {if_rvalid0, ls_rvalid0},
                         (t % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
            mem_rvalid0 = 0;
        end
        if_req = 0; ls_req = 0;
        $display("test_round_robin done");
    endtask

    task automatic wait_gnt1(input string name, input logic want_ls);
        int n = 0;
        #1;
        while (!(if_gnt1 || ls_gnt1) && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if ({if_gnt1, ls_gnt1} !== (want_ls ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL %s got if/ls=%b want %b after %0d cycles", name, {if_gnt1, ls_gnt1},
                     want_ls ? 2'b01 : 2'b10, n);
        end
        tick();
    endtask

    task automatic test_ls_prio;
        do_reset();
        if_req = 1; ls_req = 1; ls_wen = 0; if_addr = 64'h300; ls_addr = 64'h400;
        wait_gnt1("prio_ls0", 1'b1);
        wait_gnt1("prio_ls1", 1'b1);
        wait_gnt1("prio_ls2", 1'b1);
        ls_req = 0;
        wait_gnt1("prio_if", 1'b0);
        if_req = 0;
        $display("test_ls_prio done");
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        ls_req = 1; ls_wen = 0; ls_addr = 64'h8000_2000;
        #1;
        tick();
        ls_req = 0; mem_ready0 = 1;
        tick();
        mem_ready0 = 0; rst_n = 0;
        tick();
        rst_n = 1; mem_rvalid0 = 1; mem_rdata = 64'hABCD;
        #1;
        checks++;
        if ({ls_rvalid0, if_rvalid0, mem_req0} !== 3'b000) begin
            errors++; $display("FAIL rstwait_rvalid got lsv/ifv/req=%b want 000", {ls_rvalid0, if_rvalid0, mem_req0});
        end
        checks++;
        if ({mem_addr0, mem_wmask0, mem_wen0} !== 73'b0) begin
            errors++; $display("FAIL rstwait_cmd got addr=%h wmask=%h wen=%b want 0", mem_addr0, mem_wmask0, mem_wen0);
        end
        tick();
        mem_rvalid0 = 0; if_req = 1; if_addr = 64'h10;
        #1;
        checks++;
        if ({if_gnt0, mem_req0} !== 2'b10) begin
            errors++; $display("FAIL rstwait_idle got gnt/req=%b want 10", {if_gnt0, mem_req0});
        end
        if_req = 0;
        tick();
        $display("test_reset_in_wait done");
    endtask

    task automatic test_spurious_rvalid;
        do_reset();
        mem_rvalid0 = 1; mem_rdata = 64'h1234;
        #1;
        checks++;
        if ({if_rvalid0, ls_rvalid0, mem_req0} !== 3'b000) begin
            errors++; $display("FAIL spurious_rvalid got ifv/lsv/req=%b want 000", {if_rvalid0, ls_rvalid0, mem_req0});
        end
        tick();
        mem_rvalid0 = 0; ls_req = 1; ls_wen = 1;
        #1;
        checks++;
        if ({ls_gnt0, mem_req0} !== 2'b10) begin
            errors++; $display("FAIL spurious_state got gnt/req=%b want 10", {ls_gnt0, mem_req0});
        end
        ls_req = 0;
        tick();
        $display("test_spurious_rvalid done");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_round_robin();
        test_ls_prio();
        test_reset_in_wait();
        test_spurious_rvalid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
